fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that lets NUM_REQ producers share one FIFO's write port (the master side of fifo_if).
A producer holds the grant for a whole packet, up to MAX_BURST beats, so packet beats stay contiguous in the FIFO.
Output writes are registered.
Backpressure comes from the FIFO's full/almost_full flags, so no beat is lost and no write reaches a full FIFO.

---
 rtl/fifo_wr_arbiter_pkg.sv | 11 +
 rtl/fifo_wr_arbiter_if.sv | 12 +
 rtl/fifo_wr_arbiter_rr_picker.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 106 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared types and helpers for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  // Index width that never collapses to zero bits for single-entry cases.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - FIFO write-port bundle with master/slave views
interface fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wen;
  logic                  full;
  logic                  almost_full;

  modport master (output wdata, output wen, input full, input almost_full);
  modport slave  (input wdata, input wen, output full, output almost_full);
endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rtl/fifo_wr_arbiter_rr_picker.sv - combinational round-robin first-set picker
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2_min1(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [W-1:0]   off;
  logic [W:0]     sum;

  always_comb begin
    dbl = {req, req} >> ptr;
    any = 1'b0;
    off = '0;
    // Descending scan so the lowest rotated position (closest to ptr) wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (dbl[i]) begin
        any = 1'b1;
        off = W'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    idx = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin packet arbiter sharing one FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  fifo_if.master                        fifo,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t            state;
  logic [GW-1:0]         rr_ptr;
  logic [CW-1:0]         beat_cnt;
  logic                  pick_any;
  logic [GW-1:0]         pick_idx;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  can_accept;
  logic                  accept;
  logic                  burst_end;

  rr_picker #(
    .N (NUM_REQ),
    .W (GW)
  ) u_picker (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A write already in flight into the last free slot must block the next beat.
  always_comb begin
    can_accept = !fifo.full && !(fifo.almost_full && fifo.wen);
    req_ready  = '0;
    if (state == BURST && can_accept) begin
      req_ready[grant_id] = 1'b1;
    end
    accept    = (state == BURST) && can_accept && sel_valid;
    burst_end = accept && (sel_last || (beat_cnt == CW'(MAX_BURST - 1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      fifo.wen   <= 1'b0;
      fifo.wdata <= '0;
    end else begin
      fifo.wen <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id <= pick_idx;
            beat_cnt <= '0;
            busy     <= 1'b1;
            state    <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            fifo.wen   <= 1'b1;
            fifo.wdata <= sel_data;
            beat_cnt   <= beat_cnt + CW'(1);
            if (burst_end) begin
              state  <= IDLE;
              busy   <= 1'b0;
              rr_ptr <= (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for the FIFO write arbiter
module tb_fifo_wr_arbiter;

  localparam int NR    = 4;
  localparam int DW    = 32;
  localparam int MB    = 8;
  localparam int DEPTH = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_last;
  logic [NR-1:0]  req_ready;
  logic [1:0]     grant_id;
  logic           busy;

  fifo_if #(.DATA_WIDTH(DW)) fif ();

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .fifo      (fif),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int  fill;
  logic fill_load;
  int  fill_val;
  assign fif.full        = (fill >= DEPTH);
  assign fif.almost_full = (fill == DEPTH - 1);

  always @(posedge clk) begin
    if (fill_load) fill <= fill_val;
    else if (fif.wen) fill <= fill + 1;
  end

  logic [32:0] mem [NR][32];
  int          hd [NR];
  int          tl [NR];
  logic [NR-1:0] pause;

  logic [31:0] exp_w[$];
  logic [1:0]  exp_g[$];

  int checks = 0;
  int passed = 0;
  logic mon_en = 1'b0;
  logic busy_q = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (fif.wen) begin
        if (exp_w.size() == 0) begin
          checks++;
          $display("FAIL wr_extra: got write %h expected none", fif.wdata);
        end else begin
          check("wr_data", fif.wdata, exp_w.pop_front());
        end
        check("wr_not_full", 32'(fill < DEPTH), 32'd1);
      end
      if (busy && !busy_q) begin
        if (exp_g.size() == 0) begin
          checks++;
          $display("FAIL grant_extra: got grant %0d expected none", grant_id);
        end else begin
          check("grant_id", 32'(grant_id), 32'(exp_g.pop_front()));
        end
      end
    end
    busy_q = busy;
  end

  task automatic add_pkt(input int p, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      mem[p][tl[p]] = {(k == n - 1), base + 32'(k)};
      tl[p]++;
    end
  endtask

  task automatic exp_seq(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) exp_w.push_back(base + 32'(k));
  endtask

  task automatic drive();
    for (int p = 0; p < NR; p++) begin
      if (hd[p] < tl[p]) begin
        req_valid[p]         = !pause[p];
        req_data[p*DW +: DW] = mem[p][hd[p]][31:0];
        req_last[p]          = mem[p][hd[p]][32];
      end else begin
        req_valid[p]         = 1'b0;
        req_data[p*DW +: DW] = '0;
        req_last[p]          = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [NR-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready & {NR{!rst}};
    @(posedge clk);
    #1;
    for (int p = 0; p < NR; p++) if (acc[p]) hd[p]++;
    drive();
  endtask

  function automatic logic all_empty();
    for (int p = 0; p < NR; p++) if (hd[p] < tl[p]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_idle(input string name, input int max);
    int n = 0;
    while (!(all_empty() && !busy && !fif.wen) && n < max) begin
      step();
      n++;
    end
    check(name, 32'(n < max), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_gid"},   32'(grant_id), 32'd0);
    check({tag, "_wen"},   32'(fif.wen), 32'd0);
    check({tag, "_wdata"}, fif.wdata, 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    for (int p = 0; p < NR; p++) begin
      hd[p] = 0;
      tl[p] = 0;
    end
    pause     = '0;
    fill_load = 1'b1;
    fill_val  = 0;
    drive();
    step();
    fill_load = 1'b0;
    check_reset(tag);
    rst = 1'b0;
    drive();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    pause     = '0;
    fill_load = 1'b1;
    fill_val  = 0;
    for (int p = 0; p < NR; p++) begin
      hd[p] = 0;
      tl[p] = 0;
    end
    step();
    mon_en = 1'b1;

    // Single producer, 3-beat packet, then rr_ptr=2 shown by picking 3 before 0.
    do_reset("t1_rst");
    add_pkt(1, 32'hA100, 3);
    exp_seq(32'hA100, 3);
    exp_g.push_back(2'd1);
    drive();
    step();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_gid", 32'(grant_id), 32'd1);
    check("t1_ready", 32'(req_ready), 32'h2);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t1_wen", 32'(fif.wen), 32'd1);
    end
    check("t1_idle", 32'(busy), 32'd0);
    step();
    check("t1_wen_off", 32'(fif.wen), 32'd0);
    add_pkt(0, 32'hA200, 1);
    add_pkt(3, 32'hA300, 1);
    exp_g.push_back(2'd3);
    exp_g.push_back(2'd0);
    exp_w.push_back(32'hA300);
    exp_w.push_back(32'hA200);
    drive();
    run_idle("t1_done", 20);

    // Four producers with back-to-back 1-beat packets.
    do_reset("t2_rst");
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NR; p++) add_pkt(p, 32'hB000 + 32'(p*16 + r), 1);
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NR; p++) begin
        exp_w.push_back(32'hB000 + 32'(p*16 + r));
        exp_g.push_back(2'(p));
      end
    drive();
    for (int k = 0; k < 16; k++) begin
      step();
      check("t2_busy", 32'(busy), 32'((k % 2) == 0));
    end
    run_idle("t2_done", 10);

    // Two free slots, 5-beat packet.
    do_reset("t3_rst");
    fill_load = 1'b1;
    fill_val  = DEPTH - 2;
    step();
    fill_load = 1'b0;
    add_pkt(0, 32'hC000, 5);
    exp_seq(32'hC000, 5);
    exp_g.push_back(2'd0);
    drive();
    step();
    step();
    step();
    check("t3_ready_af", 32'(req_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t3_ready_full", 32'(req_ready), 32'd0);
      check("t3_wen_full", 32'(fif.wen), 32'd0);
    end
    fill_load = 1'b1;
    fill_val  = 0;
    step();
    fill_load = 1'b0;
    run_idle("t3_done", 30);

    // Forced re-arbitration after MAX_BURST beats.
    do_reset("t4_rst");
    add_pkt(2, 32'hD000, 10);
    add_pkt(3, 32'hD100, 1);
    exp_seq(32'hD000, 8);
    exp_w.push_back(32'hD100);
    exp_seq(32'hD008, 2);
    exp_g.push_back(2'd2);
    exp_g.push_back(2'd3);
    exp_g.push_back(2'd2);
    drive();
    run_idle("t4_done", 60);

    // Reset mid-burst; pending 0 and 3, restarted 1, rearbitrated from index 0.
    do_reset("t5_rst");
    add_pkt(0, 32'hE000, 1);
    exp_w.push_back(32'hE000);
    exp_g.push_back(2'd0);
    drive();
    run_idle("t5_pre", 20);
    add_pkt(1, 32'hE100, 4);
    add_pkt(0, 32'hE200, 1);
    add_pkt(3, 32'hE300, 1);
    exp_seq(32'hE100, 2);
    exp_g.push_back(2'd1);
    drive();
    step();
    step();
    step();
    rst = 1'b1;
    drive();
    step();
    check_reset("t5_mid");
    rst   = 1'b0;
    hd[1] = 0;
    exp_w.push_back(32'hE200);
    exp_seq(32'hE100, 4);
    exp_w.push_back(32'hE300);
    exp_g.push_back(2'd0);
    exp_g.push_back(2'd1);
    exp_g.push_back(2'd3);
    drive();
    run_idle("t5_done", 40);

    // Grantee stalls 3 cycles mid-packet while another waits.
    do_reset("t6_rst");
    add_pkt(1, 32'hF100, 4);
    add_pkt(2, 32'hF200, 1);
    exp_seq(32'hF100, 4);
    exp_w.push_back(32'hF200);
    exp_g.push_back(2'd1);
    exp_g.push_back(2'd2);
    drive();
    step();
    step();
    step();
    pause[1] = 1'b1;
    drive();
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_gid", 32'(grant_id), 32'd1);
      check("t6_busy", 32'(busy), 32'd1);
      check("t6_wen", 32'(fif.wen), 32'd0);
    end
    pause[1] = 1'b0;
    drive();
    run_idle("t6_done", 20);

    step();
    check("wr_queue_drained", 32'(exp_w.size()), 32'd0);
    check("grant_queue_drained", 32'(exp_g.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
